// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-to-parallel frame receiver.
// Receives start(0), WIDTH data bits LSB-first, an optional even-parity bit and
// stop(1). Each good word is presented on a valid/ready parallel output.
// Framing errors discard the word. Overruns drop the new word and keep the old one.
module sipo_frame_rx #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             si,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DATA      = 3'd1;
    localparam logic [2:0] S_PARITY    = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] shreg;
    logic             p_err;
    logic             good_stop;
    logic             bad_stop;
    logic             last_bit;

    assign last_bit  = (counter == CW'(WIDTH - 1));
    assign good_stop = (state == S_STOP) && si;
    assign bad_stop  = (state == S_STOP) && !si;
    assign busy      = (state != S_IDLE);

    // Frame sequencing: start detect, data shift, parity, stop check, and
    // the wait for the line to return high after a framing error.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= S_IDLE;
            counter <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!si) begin
                        state   <= S_DATA;
                        counter <= '0;
                    end
                end
                S_DATA: begin
                    shreg[counter] <= si;
                    counter        <= counter + CW'(1);
                    if (last_bit) begin
                        state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    state <= S_STOP;
                end
                S_STOP: begin
                    state <= si ? S_IDLE : S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    // A line stuck low must not look like a fresh start bit.
                    if (si) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Even-parity check: data XOR parity bit must be 0; stays 0 without parity.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            p_err <= 1'b0;
        end else if (state == S_PARITY) begin
            p_err <= (PARITY_EN != 0) ? (si ^ (^shreg)) : 1'b0;
        end
    end

    // Output holding register with valid/ready handshake and error pulses.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= 1'b0;
            if (good_stop) begin
                // A word consumed on this same edge frees the slot for the new one.
                if (!dout_valid || dout_ready) begin
                    dout       <= shreg;
                    parity_err <= p_err;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: directed vectors for sipo_frame_rx.
// Instance a: WIDTH=8 with parity. Instance b: WIDTH=4 without parity.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_sipo_frame_rx;

    logic       clk;
    logic       clear_n;
    logic       si_a, si_b;
    logic       dout_ready_a, dout_ready_b;
    logic [7:0] dout_a;
    logic [3:0] dout_b;
    logic       dout_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a;
    logic       dout_valid_b, parity_err_b, frame_err_b, overrun_b, busy_b;

    int nvec = 0;
    int nerr = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    int base;

    sipo_frame_rx #(.WIDTH(8), .PARITY_EN(1)) dut_a (
        .clk(clk), .clear_n(clear_n), .si(si_a),
        .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
        .parity_err(parity_err_a), .frame_err(frame_err_a),
        .overrun(overrun_a), .busy(busy_a)
    );

    sipo_frame_rx #(.WIDTH(4), .PARITY_EN(0)) dut_b (
        .clk(clk), .clear_n(clear_n), .si(si_b),
        .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b),
        .overrun(overrun_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the one-cycle flags of instance a.
    always @(negedge clk) begin
        if (overrun_a)   ov_cnt++;
        if (frame_err_a) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input logic b);
        si_a = b;
        @(negedge clk);
    endtask

    task automatic tick_b(input logic b);
        si_b = b;
        @(negedge clk);
    endtask

    // One frame on instance a; dout_ready takes rdy_stop only on the stop edge.
    task automatic send_a(input logic [7:0] d, input logic p, input logic stop, input logic rdy_stop);
        logic rdy_body;
        rdy_body = dout_ready_a;
        tick(1'b0);
        for (int i = 0; i < 8; i++) tick(d[i]);
        tick(p);
        dout_ready_a = rdy_stop;
        tick(stop);
        dout_ready_a = rdy_body;
    endtask

    initial begin
        clear_n = 1'b0;
        si_a = 1'b1;
        si_b = 1'b1;
        dout_ready_a = 1'b0;
        dout_ready_b = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_dout",    32'(dout_a), 32'h0);
        chk("rst_valid",   32'(dout_valid_a), 32'h0);
        chk("rst_perr",    32'(parity_err_a), 32'h0);
        chk("rst_ferr",    32'(frame_err_a), 32'h0);
        chk("rst_ovr",     32'(overrun_a), 32'h0);
        chk("rst_busy",    32'(busy_a), 32'h0);
        chk("rst_busy_b",  32'(busy_b), 32'h0);
        clear_n = 1'b1;

        // reset mid-DATA, then idle line
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        chk("mid_busy", 32'(busy_a), 32'h1);
        #2 clear_n = 1'b0;
        #1;
        chk("async_busy",  32'(busy_a), 32'h0);
        chk("async_valid", 32'(dout_valid_a), 32'h0);
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            chk("idle_valid", 32'(dout_valid_a), 32'h0);
            chk("idle_busy",  32'(busy_a), 32'h0);
            chk("idle_ferr",  32'(frame_err_a), 32'h0);
        end
        chk("idle_dout", 32'(dout_a), 32'h0);

        // good frame 0xA5, parity 0
        dout_ready_a = 1'b1;
        send_a(8'hA5, 1'b0, 1'b1, 1'b1);
        chk("a5_valid", 32'(dout_valid_a), 32'h1);
        chk("a5_dout",  32'(dout_a), 32'hA5);
        chk("a5_perr",  32'(parity_err_a), 32'h0);
        chk("a5_busy",  32'(busy_a), 32'h0);
        tick(1'b1);
        chk("a5_taken", 32'(dout_valid_a), 32'h0);

        // same frame with wrong parity bit
        send_a(8'hA5, 1'b1, 1'b1, 1'b1);
        chk("pe_valid", 32'(dout_valid_a), 32'h1);
        chk("pe_dout",  32'(dout_a), 32'hA5);
        chk("pe_perr",  32'(parity_err_a), 32'h1);
        chk("pe_ferr",  32'(frame_err_a), 32'h0);
        tick(1'b1);
        chk("pe_taken", 32'(dout_valid_a), 32'h0);

        // framing error on 0x3C, line held low, then 0x11
        base = fe_cnt;
        send_a(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("fe_pulse", 32'(frame_err_a), 32'h1);
        chk("fe_valid", 32'(dout_valid_a), 32'h0);
        chk("fe_busy",  32'(busy_a), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            chk("wait_busy",  32'(busy_a), 32'h1);
            chk("wait_ferr",  32'(frame_err_a), 32'h0);
            chk("wait_valid", 32'(dout_valid_a), 32'h0);
        end
        tick(1'b1);
        chk("wait_exit", 32'(busy_a), 32'h0);
        chk("fe_count",  32'(fe_cnt - base), 32'h1);
        send_a(8'h11, 1'b0, 1'b1, 1'b1);
        chk("x11_valid", 32'(dout_valid_a), 32'h1);
        chk("x11_dout",  32'(dout_a), 32'h11);
        chk("x11_perr",  32'(parity_err_a), 32'h0);
        tick(1'b1);
        chk("x11_taken", 32'(dout_valid_a), 32'h0);

        // back-to-back frames into a full output
        dout_ready_a = 1'b0;
        base = ov_cnt;
        send_a(8'h01, 1'b1, 1'b1, 1'b0);
        chk("b1_valid", 32'(dout_valid_a), 32'h1);
        chk("b1_dout",  32'(dout_a), 32'h01);
        chk("b1_ovr",   32'(overrun_a), 32'h0);
        send_a(8'h02, 1'b1, 1'b1, 1'b0);
        chk("b2_ovr",   32'(overrun_a), 32'h1);
        chk("b2_dout",  32'(dout_a), 32'h01);
        send_a(8'h03, 1'b0, 1'b1, 1'b0);
        chk("b3_ovr",   32'(overrun_a), 32'h1);
        chk("b3_dout",  32'(dout_a), 32'h01);
        chk("b3_perr",  32'(parity_err_a), 32'h0);
        tick(1'b1);
        chk("b3_ovr_end", 32'(overrun_a), 32'h0);
        chk("b3_valid",   32'(dout_valid_a), 32'h1);
        chk("ovr_count",  32'(ov_cnt - base), 32'h2);
        dout_ready_a = 1'b1;
        tick(1'b1);
        chk("b_drain", 32'(dout_valid_a), 32'h0);

        // accept and load on the same edge
        dout_ready_a = 1'b0;
        base = ov_cnt;
        send_a(8'h01, 1'b1, 1'b1, 1'b0);
        chk("s1_dout", 32'(dout_a), 32'h01);
        send_a(8'h02, 1'b1, 1'b1, 1'b1);
        chk("s2_dout",  32'(dout_a), 32'h02);
        chk("s2_valid", 32'(dout_valid_a), 32'h1);
        chk("s2_ovr",   32'(overrun_a), 32'h0);
        tick(1'b1);
        chk("s2_hold",  32'(dout_a), 32'h02);
        chk("s2_hold_v", 32'(dout_valid_a), 32'h1);
        chk("s_no_ovr", 32'(ov_cnt - base), 32'h0);
        dout_ready_a = 1'b1;
        tick(1'b1);
        chk("s_drain", 32'(dout_valid_a), 32'h0);

        // WIDTH=4, no parity: 0,1,1,0,1,1 -> 0xB
        tick_b(1'b0);
        tick_b(1'b1);
        tick_b(1'b1);
        tick_b(1'b0);
        tick_b(1'b1);
        chk("b4_busy_stop",  32'(busy_b), 32'h1);
        chk("b4_valid_stop", 32'(dout_valid_b), 32'h0);
        tick_b(1'b1);
        chk("b4_valid", 32'(dout_valid_b), 32'h1);
        chk("b4_dout",  32'(dout_b), 32'hB);
        chk("b4_perr",  32'(parity_err_b), 32'h0);
        chk("b4_busy",  32'(busy_b), 32'h0);
        tick_b(1'b1);
        chk("b4_taken", 32'(dout_valid_b), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
